// File: rtl/pipe_hazard_ctrl.sv
// Pipeline stall/flush controller: per-stage hold, bubble, PC redirect, watchdog.
// Optional perf counters are enabled with the PIPE_CTRL_PERF_EN macro.
module pipe_hazard_ctrl #(
  parameter int NSTAGE = 6,
  parameter int XLEN   = 32,
  parameter int WD_W   = 10
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic [NSTAGE-1:0]      stallreq,
  input  logic [NSTAGE-1:0]      flushreq,
  input  logic [NSTAGE*XLEN-1:0] flush_pc,
  output logic [NSTAGE-1:0]      stall,
  output logic [NSTAGE-1:0]      flush,
  output logic                   redirect_valid,
  output logic [XLEN-1:0]        redirect_pc,
  output logic                   flush_pending,
  output logic                   stall_timeout,
  output logic [31:0]            perf_stall_cycles,
  output logic [31:0]            perf_flush_count
);

  localparam int SW = (NSTAGE > 1) ? $clog2(NSTAGE) : 1;
  localparam logic [WD_W-1:0] WD_MAX = '1;
  localparam logic [WD_W-1:0] WD_PRE = WD_MAX - 1'b1;

  logic [SW-1:0]   s_idx;
  logic [SW-1:0]   f_idx;
  logic [XLEN-1:0] f_pc;

  logic            pend_valid;
  logic [SW-1:0]   pend_stage;
  logic [XLEN-1:0] pend_pc;

  logic [WD_W-1:0] wd_cnt;
  logic            timeout_q;

  logic            live;
  logic            blocked;
  logic            older;
  logic            sel_a;
  logic            sel_b;
  logic            issue;
  logic            cap;
  logic [SW-1:0]   iss_stage;
  logic [XLEN-1:0] iss_pc;

  logic            unused;
  assign unused = ^{stallreq[0], flushreq[0],
                    flush_pc[XLEN-1:0]};

  // Later stages overwrite earlier ones, so the oldest request wins.
  always_comb begin
    s_idx = '0;
    f_idx = '0;
    f_pc  = '0;
    for (int k = 1; k < NSTAGE; k++) begin
      if (stallreq[k]) s_idx = SW'(k);
      if (flushreq[k]) begin
        f_idx = SW'(k);
        f_pc  = flush_pc[k*XLEN +: XLEN];
      end
    end
  end

  always_comb begin
    live    = (f_idx != '0);
    blocked = live && (s_idx >= f_idx);
    older   = !pend_valid || (f_idx > pend_stage);
    sel_a   = !RST && live && !blocked && older;
    sel_b   = !RST && !sel_a && pend_valid &&
              (s_idx < pend_stage);
    issue   = sel_a || sel_b;
    cap     = blocked && older;
    iss_stage = sel_a ? f_idx : pend_stage;
    iss_pc    = sel_a ? f_pc  : pend_pc;
  end

  always_comb begin
    stall = '0;
    flush = '0;
    for (int i = 0; i < NSTAGE; i++) begin
      if (!RST && s_idx != '0 && SW'(i) <= s_idx)
        stall[i] = 1'b1;
    end
    for (int i = 1; i < NSTAGE; i++) begin
      if (issue && SW'(i) < iss_stage)
        flush[i] = 1'b1;
    end
  end

  assign redirect_valid = issue;
  assign redirect_pc    = issue ? iss_pc : '0;
  assign flush_pending  = pend_valid;
  assign stall_timeout  = timeout_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pend_valid <= 1'b0;
      pend_stage <= '0;
      pend_pc    <= '0;
    end else if (cap) begin
      pend_valid <= 1'b1;
      pend_stage <= f_idx;
      pend_pc    <= f_pc;
    end else if (issue) begin
      pend_valid <= 1'b0;
      pend_stage <= '0;
      pend_pc    <= '0;
    end
  end

  // Timeout rises on the edge that completes the last allowed stall cycle.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wd_cnt    <= '0;
      timeout_q <= 1'b0;
    end else if (s_idx != '0) begin
      if (wd_cnt != WD_MAX) wd_cnt <= wd_cnt + 1'b1;
      if (wd_cnt >= WD_PRE) timeout_q <= 1'b1;
    end else begin
      wd_cnt <= '0;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] sc_q;
  logic [31:0] fc_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      sc_q <= '0;
      fc_q <= '0;
    end else begin
      if (s_idx != '0) sc_q <= sc_q + 32'd1;
      if (issue)       fc_q <= fc_q + 32'd1;
    end
  end

  assign perf_stall_cycles = sc_q;
  assign perf_flush_count  = fc_q;
`else
  assign perf_stall_cycles = '0;
  assign perf_flush_count  = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios plus
// randomized traffic against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int N  = 6;
  localparam int XL = 32;

  logic          CLK = 1'b0;
  logic          RST = 1'b1;
  logic [N-1:0]  stallreq = '0;
  logic [N-1:0]  flushreq = '0;
  logic [N*XL-1:0] flush_pc = '0;
  logic [N-1:0]  stall;
  logic [N-1:0]  flush;
  logic          redirect_valid;
  logic [XL-1:0] redirect_pc;
  logic          flush_pending;
  logic          stall_timeout;
  logic [31:0]   perf_stall_cycles;
  logic [31:0]   perf_flush_count;

  pipe_hazard_ctrl #(.NSTAGE(N), .XLEN(XL), .WD_W(10)) dut (
    .CLK(CLK), .RST(RST),
    .stallreq(stallreq), .flushreq(flushreq),
    .flush_pc(flush_pc),
    .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .flush_pending(flush_pending),
    .stall_timeout(stall_timeout),
    .perf_stall_cycles(perf_stall_cycles),
    .perf_flush_count(perf_flush_count)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference state: pending redirect, stall run length, counters.
  bit          m_pv;
  int          m_ps;
  logic [31:0] m_pc;
  int          m_run;
  bit          m_to;
  logic [31:0] m_sc;
  logic [31:0] m_fc;

  bit          n_pv;
  int          n_ps;
  logic [31:0] n_pc;
  int          n_run;
  bit          n_to;
  logic [31:0] n_sc;
  logic [31:0] n_fc;

  logic [N-1:0]  e_stall;
  logic [N-1:0]  e_flush;
  logic          e_rv;
  logic [XL-1:0] e_rpc;
  logic [31:0]   e_psc;
  logic [31:0]   e_pfc;

  task automatic model_eval();
    int s, f, ik;
    bit iss;
    logic [31:0] ipc;
    s = 0; f = 0; ik = 0; iss = 0; ipc = '0;
    for (int k = 1; k < N; k++) begin
      if (stallreq[k]) s = k;
      if (flushreq[k]) f = k;
    end
    if (!RST) begin
      if (f > 0 && s < f && (!m_pv || f > m_ps)) begin
        iss = 1; ik = f; ipc = flush_pc[f*XL +: XL];
      end else if (m_pv && s < m_ps) begin
        iss = 1; ik = m_ps; ipc = m_pc;
      end
    end
    e_stall = (RST || s == 0) ? '0 : N'((1 << (s + 1)) - 1);
    e_flush = iss ? N'((1 << ik) - 2) : '0;
    e_rv    = iss;
    e_rpc   = iss ? ipc : '0;
`ifdef PIPE_CTRL_PERF_EN
    e_psc = m_sc;
    e_pfc = m_fc;
`else
    e_psc = '0;
    e_pfc = '0;
`endif
    if (RST) begin
      n_pv = 0; n_ps = 0; n_pc = '0;
      n_run = 0; n_to = 0; n_sc = '0; n_fc = '0;
    end else begin
      n_pv = m_pv; n_ps = m_ps; n_pc = m_pc;
      if (f > 0 && s >= f && (!m_pv || f > m_ps)) begin
        n_pv = 1; n_ps = f; n_pc = flush_pc[f*XL +: XL];
      end else if (iss) begin
        n_pv = 0; n_ps = 0; n_pc = '0;
      end
      n_run = (s > 0) ? m_run + 1 : 0;
      n_to  = m_to || (n_run >= 1023);
      n_sc  = m_sc + ((s > 0) ? 32'd1 : 32'd0);
      n_fc  = m_fc + (iss ? 32'd1 : 32'd0);
    end
  endtask

  task automatic adv();
    model_eval();
    @(posedge CLK);
    m_pv = n_pv; m_ps = n_ps; m_pc = n_pc;
    m_run = n_run; m_to = n_to;
    m_sc = n_sc; m_fc = n_fc;
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] sr,
                        input logic [N-1:0] fr);
    stallreq = sr;
    flushreq = fr;
    #2;
    model_eval();
  endtask

  task automatic test_reset();
    RST = 1'b1;
    flush_pc = {6{32'h1234_5678}};
    set_in(6'b011110, 6'b001100);
    n_chk++;
    if (stall !== '0) begin
      n_fail++;
      $display("FAIL rst_stall: got %b want 0", stall);
    end
    n_chk++;
    if (flush !== '0 || redirect_valid !== 1'b0 ||
        redirect_pc !== '0) begin
      n_fail++;
      $display("FAIL rst_redir: flush %b rv %b pc %h want 0",
               flush, redirect_valid, redirect_pc);
    end
    adv();
    adv();
    n_chk++;
    if (flush_pending !== 1'b0 || stall_timeout !== 1'b0 ||
        perf_stall_cycles !== '0 || perf_flush_count !== '0) begin
      n_fail++;
      $display("FAIL rst_regs: fp %b to %b sc %0d fc %0d want 0",
               flush_pending, stall_timeout,
               perf_stall_cycles, perf_flush_count);
    end
    RST = 1'b0;
  endtask

  task automatic test_stall_prio();
    logic [N-1:0] sr [4];
    logic [N-1:0] ex [4];
    sr[0] = 6'b010000; ex[0] = 6'b011111;
    sr[1] = 6'b000010; ex[1] = 6'b000011;
    sr[2] = 6'b010010; ex[2] = 6'b011111;
    sr[3] = 6'b000000; ex[3] = 6'b000000;
    for (int i = 0; i < 4; i++) begin
      set_in(sr[i], '0);
      n_chk++;
      if (stall !== ex[i]) begin
        n_fail++;
        $display("FAIL stall_prio[%0d]: got %b want %b",
                 i, stall, ex[i]);
      end
      adv();
    end
  endtask

  task automatic test_flush_basic();
    flush_pc[3*XL +: XL] = 32'h8000_0040;
    set_in('0, 6'b001000);
    n_chk++;
    if (flush !== 6'b000110 || redirect_valid !== 1'b1 ||
        redirect_pc !== 32'h8000_0040) begin
      n_fail++;
      $display("FAIL flush_basic: flush %b rv %b pc %h want 000110 1 80000040",
               flush, redirect_valid, redirect_pc);
    end
    adv();
    set_in('0, '0);
    n_chk++;
    if (flush !== '0 || redirect_valid !== 1'b0 ||
        redirect_pc !== '0) begin
      n_fail++;
      $display("FAIL flush_after: flush %b rv %b pc %h want 0",
               flush, redirect_valid, redirect_pc);
    end
    adv();
  endtask

  task automatic test_deferred();
    flush_pc[3*XL +: XL] = 32'h8000_0100;
    for (int c = 0; c < 3; c++) begin
      set_in(6'b010000, (c == 0) ? 6'b001000 : 6'b000000);
      if (c == 1) flush_pc[3*XL +: XL] = 32'hDEAD_BEEF;
      n_chk++;
      if (redirect_valid !== 1'b0 ||
          flush_pending !== (c > 0)) begin
        n_fail++;
        $display("FAIL defer_hold[%0d]: rv %b fp %b want 0 %0d",
                 c, redirect_valid, flush_pending, c > 0);
      end
      adv();
    end
    set_in('0, '0);
    n_chk++;
    if (flush !== 6'b000110 || redirect_valid !== 1'b1 ||
        redirect_pc !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL defer_issue: flush %b rv %b pc %h want 000110 1 80000100",
               flush, redirect_valid, redirect_pc);
    end
    adv();
    set_in('0, '0);
    n_chk++;
    if (flush_pending !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL defer_clear: fp %b rv %b want 0 0",
               flush_pending, redirect_valid);
    end
    adv();
  endtask

  task automatic test_replace();
    logic [31:0] fc0;
    flush_pc[2*XL +: XL] = 32'h0000_2000;
    flush_pc[3*XL +: XL] = 32'h0000_3000;
    set_in(6'b000100, 6'b000100);
    n_chk++;
    if (redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL repl_block: rv %b want 0", redirect_valid);
    end
    adv();
    set_in('0, 6'b001000);
    fc0 = m_fc;
    n_chk++;
    if (flush_pending !== 1'b1 || flush !== 6'b000110 ||
        redirect_pc !== 32'h0000_3000) begin
      n_fail++;
      $display("FAIL repl_issue: fp %b flush %b pc %h want 1 000110 00003000",
               flush_pending, flush, redirect_pc);
    end
    adv();
    set_in('0, '0);
    n_chk++;
    if (flush_pending !== 1'b0 || redirect_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL repl_drop: fp %b rv %b want 0 0",
               flush_pending, redirect_valid);
    end
`ifdef PIPE_CTRL_PERF_EN
    n_chk++;
    if (perf_flush_count !== fc0 + 32'd1) begin
      n_fail++;
      $display("FAIL repl_perf: got %0d want %0d",
               perf_flush_count, fc0 + 32'd1);
    end
`endif
    adv();
  endtask

  task automatic test_watchdog();
    for (int i = 0; i < 1023; i++) begin
      set_in(6'b010000, '0);
      if (i == 1022) begin
        n_chk++;
        if (stall_timeout !== 1'b0) begin
          n_fail++;
          $display("FAIL wd_early: got %b want 0", stall_timeout);
        end
      end
      adv();
    end
    n_chk++;
    if (stall_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_fire: got %b want 1", stall_timeout);
    end
    for (int i = 0; i < 3; i++) begin
      set_in('0, '0);
      adv();
    end
    n_chk++;
    if (stall_timeout !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_sticky: got %b want 1", stall_timeout);
    end
    RST = 1'b1;
    set_in('0, '0);
    adv();
    RST = 1'b0;
    set_in('0, '0);
    n_chk++;
    if (stall_timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_clear: got %b want 0", stall_timeout);
    end
    adv();
  endtask

  task automatic test_reset_pending();
    flush_pc[3*XL +: XL] = 32'h0000_7777;
    set_in(6'b010000, 6'b001000);
    adv();
    set_in(6'b010000, '0);
    n_chk++;
    if (flush_pending !== 1'b1) begin
      n_fail++;
      $display("FAIL rp_setup: fp %b want 1", flush_pending);
    end
    RST = 1'b1;
    set_in(6'b010000, '0);
    adv();
    RST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in('0, '0);
      n_chk++;
      if (flush_pending !== 1'b0 || redirect_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rp_after[%0d]: fp %b rv %b want 0 0",
                 i, flush_pending, redirect_valid);
      end
      adv();
    end
  endtask

  task automatic test_random();
    logic [N-1:0] sr, fr;
    for (int c = 0; c < 600; c++) begin
      RST = ($urandom_range(0, 59) == 0);
      sr = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      fr = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      for (int k = 0; k < N; k++)
        flush_pc[k*XL +: XL] = $urandom;
      set_in(sr, fr);
      n_chk++;
      if (stall !== e_stall) begin
        n_fail++;
        $display("FAIL rnd_stall@%0d: got %b want %b", c, stall, e_stall);
      end
      n_chk++;
      if (flush !== e_flush) begin
        n_fail++;
        $display("FAIL rnd_flush@%0d: got %b want %b", c, flush, e_flush);
      end
      n_chk++;
      if (redirect_valid !== e_rv || redirect_pc !== e_rpc) begin
        n_fail++;
        $display("FAIL rnd_redir@%0d: got %b %h want %b %h",
                 c, redirect_valid, redirect_pc, e_rv, e_rpc);
      end
      n_chk++;
      if (flush_pending !== m_pv || stall_timeout !== m_to) begin
        n_fail++;
        $display("FAIL rnd_state@%0d: fp %b to %b want %b %b",
                 c, flush_pending, stall_timeout, m_pv, m_to);
      end
      n_chk++;
      if (perf_stall_cycles !== e_psc || perf_flush_count !== e_pfc) begin
        n_fail++;
        $display("FAIL rnd_perf@%0d: got %0d %0d want %0d %0d",
                 c, perf_stall_cycles, perf_flush_count, e_psc, e_pfc);
      end
      adv();
    end
    RST = 1'b0;
  endtask

  initial begin
    test_reset();
    test_stall_prio();
    test_flush_basic();
    test_deferred();
    test_replace();
    test_watchdog();
    test_reset_pending();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
